// File: rtl/serial_adder_driver.sv
// serial_adder_driver: takes a parallel operand pair, streams it LSB-first
// into an external bit-serial adder, collects the serial sum bits and returns
// the W-bit result.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Valid holds its data until that edge. Ready never depends
// combinationally on valid.
// Input side:  in_vld/in_rdy.   Output side: res_vld/res_rdy.
// Serial side: ser_vld is a beat qualifier with no back-pressure. ser_en
// decides whether a beat is offered in the current cycle.
//
// The external adder's active-high rst must be tied to !rst_n. A mid-frame
// reset can then never leave a stale carry inside the adder.
module serial_adder_driver #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         ser_en,
   output logic         ser_vld,
   output logic         ser_a,
   output logic         ser_b,
   output logic         ser_last,
   input  logic         ser_sum,
   output logic         res_vld,
   input  logic         res_rdy,
   output logic [W-1:0] res_sum
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic [W-1:0]  sum_shifted;
   logic [CW-1:0] cnt_q;
   logic          accept;
   logic          beat;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and output decode. Outputs depend only on state, registers,
   // rst_n and ser_en.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      beat      = 1'b0;
      in_rdy    = 1'b0;
      ser_vld   = 1'b0;
      ser_a     = 1'b0;
      ser_b     = 1'b0;
      ser_last  = 1'b0;
      res_vld   = 1'b0;
      res_sum   = '0;
      case (state)
         IDLE: begin
            // in_rdy is forced low while reset is held
            in_rdy = rst_n;
            accept = in_vld;
            if (in_vld) state_nxt = SHIFT;
         end
         SHIFT: begin
            beat     = ser_en;
            ser_vld  = ser_en;
            ser_a    = ser_en & a_q[0];
            ser_b    = ser_en & b_q[0];
            ser_last = ser_en && (cnt_q == LAST_CNT);
            if (ser_last) state_nxt = DONE;
         end
         DONE: begin
            res_vld = 1'b1;
            res_sum = sum_q;
            if (res_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The sum bit from the adder enters at the MSB. After W beats bit i holds beat i.
   always_comb begin
      sum_shifted        = sum_q >> 1;
      sum_shifted[W-1]   = ser_sum;
   end

   // Operand, sum and beat-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         sum_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         a_q   <= in_a;
         b_q   <= in_b;
         cnt_q <= '0;
      end else if (beat) begin
         a_q   <= a_q >> 1;
         b_q   <= b_q >> 1;
         sum_q <= sum_shifted;
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_serial_adder_driver.sv
// Bench for serial_adder_driver. It drives a W=8 instance and a W=1
// instance. Each instance is paired with a behavioural bit-serial adder
// model whose carry clears on last and on reset.
module tb_serial_adder_driver;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- W=8 instance ----------------
   logic         in_vld, in_rdy, ser_en, ser_vld, ser_a, ser_b, ser_last, ser_sum;
   logic         res_vld, res_rdy;
   logic [W-1:0] in_a, in_b, res_sum;
   logic         carry8;

   serial_adder_driver #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
      .in_a(in_a), .in_b(in_b), .ser_en(ser_en), .ser_vld(ser_vld),
      .ser_a(ser_a), .ser_b(ser_b), .ser_last(ser_last), .ser_sum(ser_sum),
      .res_vld(res_vld), .res_rdy(res_rdy), .res_sum(res_sum)
   );

   // adder model: sum combinational, carry registered, cleared on last/reset
   assign ser_sum = ser_a ^ ser_b ^ carry8;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       carry8 <= 1'b0;
      else if (ser_vld) carry8 <= ser_last ? 1'b0 : ((ser_a & ser_b) | (carry8 & (ser_a ^ ser_b)));
   end

   // ---------------- W=1 instance ----------------
   logic n1_in_vld, n1_in_rdy, n1_ser_en, n1_ser_vld, n1_ser_a, n1_ser_b, n1_ser_last;
   logic n1_ser_sum, n1_res_vld, n1_res_rdy, carry1;
   logic [0:0] n1_in_a, n1_in_b, n1_res_sum;

   serial_adder_driver #(.W(1)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .in_vld(n1_in_vld), .in_rdy(n1_in_rdy),
      .in_a(n1_in_a), .in_b(n1_in_b), .ser_en(n1_ser_en), .ser_vld(n1_ser_vld),
      .ser_a(n1_ser_a), .ser_b(n1_ser_b), .ser_last(n1_ser_last), .ser_sum(n1_ser_sum),
      .res_vld(n1_res_vld), .res_rdy(n1_res_rdy), .res_sum(n1_res_sum)
   );

   assign n1_ser_sum = n1_ser_a ^ n1_ser_b ^ carry1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          carry1 <= 1'b0;
      else if (n1_ser_vld) carry1 <= n1_ser_last ? 1'b0 :
                                     ((n1_ser_a & n1_ser_b) | (carry1 & (n1_ser_a ^ n1_ser_b)));
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [0:0]   exp1_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Offer an operand pair and wait (bounded) for acceptance. The expected sum is pushed at the accepting edge.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
      int waited = 0;
      logic [W-1:0] s;
      @(negedge clk);
      in_a = a; in_b = b; in_vld = 1'b1;
      while (!in_rdy && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("accept_in_rdy", in_rdy, 1'b1);
      @(posedge clk);
      s = a + b;
      exp_q.push_back(s);
      #1 in_vld = 1'b0;
   endtask

   // Apply a ser_en pattern (MSB first, then 1s) and check the serial stream on every cycle.
   task automatic run_shift(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [15:0] pat, input int plen);
      int beats = 0;
      int cycles = 0;
      int exp_cycles = 0;
      int ones = 0;
      bit done = 1'b0;
      for (int i = 0; ones < W; i++) begin
         if (i >= plen) ones++;
         else if (pat[plen-1-i]) ones++;
         exp_cycles++;
      end
      while (!done && cycles < 100) begin
         ser_en = (cycles < plen) ? pat[plen-1-cycles] : 1'b1;
         @(negedge clk);
         check("ser_vld", ser_vld, ser_en);
         check("in_rdy_busy", in_rdy, 1'b0);
         check("res_vld_busy", res_vld, 1'b0);
         if (ser_vld) begin
            check("ser_a", ser_a, a[beats]);
            check("ser_b", ser_b, b[beats]);
            beats++;
         end else begin
            check("ser_a_bubble", ser_a, 1'b0);
         end
         check("ser_last", ser_last, (ser_vld && beats == W));
         done = ser_vld && (beats == W);
         @(posedge clk);
         #1 cycles++;
      end
      check("beats", beats, W);
      check("shift_cycles", cycles, exp_cycles);
      ser_en = 1'b1;
   endtask

   // Wait in DONE for hold cycles with res_rdy=0 while pulsing in_vld, then take the result.
   task automatic take_result(input int hold);
      logic [W-1:0] held;
      logic [W-1:0] want;
      res_rdy = 1'b0;
      @(negedge clk);
      check("res_vld_rise", res_vld, 1'b1);
      held = res_sum;
      for (int k = 0; k < hold; k++) begin
         in_vld = (k % 2 == 0);
         in_a = W'($urandom_range(0, 255));
         in_b = W'($urandom_range(0, 255));
         @(negedge clk);
         check("res_vld_hold", res_vld, 1'b1);
         check("res_sum_stable", res_sum, held);
         check("in_rdy_done", in_rdy, 1'b0);
         check("ser_vld_done", ser_vld, 1'b0);
      end
      in_vld = 1'b0;
      res_rdy = 1'b1;
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         check("res_sum", res_sum, want);
      end
      @(posedge clk);
      #1 res_rdy = 1'b0;
      @(negedge clk);
      check("res_vld_fall", res_vld, 1'b0);
      check("in_rdy_back", in_rdy, 1'b1);
   endtask

   // One W=1 frame. ser_en and res_rdy are held at 1 on that instance.
   task automatic frame_w1(input logic a, input logic b);
      logic [0:0] s;
      logic [0:0] want;
      @(negedge clk);
      n1_in_a = a; n1_in_b = b; n1_in_vld = 1'b1;
      check("w1_in_rdy", n1_in_rdy, 1'b1);
      @(posedge clk);
      s = a + b;
      exp1_q.push_back(s);
      #1 n1_in_vld = 1'b0;
      @(negedge clk);
      check("w1_ser_vld", n1_ser_vld, 1'b1);
      check("w1_ser_last", n1_ser_last, 1'b1);
      check("w1_ser_a", n1_ser_a, a);
      check("w1_ser_b", n1_ser_b, b);
      @(negedge clk);
      check("w1_res_vld", n1_res_vld, 1'b1);
      check("w1_sb_depth", exp1_q.size(), 1);
      if (exp1_q.size() > 0) begin
         want = exp1_q.pop_front();
         check("w1_res_sum", n1_res_sum, want);
      end
      @(negedge clk);
      check("w1_idle", n1_in_rdy, 1'b1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [W-1:0] ra, rb;
      rst_n = 1'b0;
      in_vld = 1'b0; in_a = '0; in_b = '0; ser_en = 1'b1; res_rdy = 1'b0;
      n1_in_vld = 1'b0; n1_in_a = '0; n1_in_b = '0; n1_ser_en = 1'b1; n1_res_rdy = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_rdy", in_rdy, 1'b0);
      check("rst_ser_vld", ser_vld, 1'b0);
      check("rst_res_vld", res_vld, 1'b0);
      check("rst_res_sum", res_sum, 0);
      check("rst_w1_in_rdy", n1_in_rdy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_rdy", in_rdy, 1'b1);

      // basic frame, overflow, then carry-independence frame
      accept(8'h3C, 8'h5A); run_shift(8'h3C, 8'h5A, 16'h0, 0); take_result(0);
      accept(8'hFF, 8'h01); run_shift(8'hFF, 8'h01, 16'h0, 0); take_result(0);
      accept(8'h01, 8'h01); run_shift(8'h01, 8'h01, 16'h0, 0); take_result(0);

      // stall bubbles
      accept(8'hA5, 8'h0F); run_shift(8'hA5, 8'h0F, 16'h0DB7, 12); take_result(0);

      // back-pressure on the result
      accept(8'hC3, 8'h7E); run_shift(8'hC3, 8'h7E, 16'h0, 0); take_result(5);

      // reset during beat 4
      accept(8'h55, 8'hAA);
      ser_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("beat4_vld", ser_vld, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_ser_vld", ser_vld, 1'b0);
      check("abort_ser_a", ser_a, 1'b0);
      check("abort_ser_b", ser_b, 1'b0);
      check("abort_ser_last", ser_last, 1'b0);
      check("abort_res_vld", res_vld, 1'b0);
      check("abort_res_sum", res_sum, 0);
      check("abort_in_rdy", in_rdy, 1'b0);
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_rdy", in_rdy, 1'b1);
      check("post_rst_res_vld", res_vld, 1'b0);
      accept(8'h12, 8'h34); run_shift(8'h12, 8'h34, 16'h0, 0); take_result(0);

      // random operands with random stall patterns and back-pressure
      for (int f = 0; f < 6; f++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         accept(ra, rb);
         run_shift(ra, rb, 16'($urandom_range(0, 4095)), 12);
         take_result($urandom_range(0, 3));
      end

      // W=1 instance
      frame_w1(1'b1, 1'b1);
      frame_w1(1'b1, 1'b0);

      check("sb_empty", exp_q.size(), 0);
      check("w1_sb_empty", exp1_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
